// File: rtl/fifo_buf_pkg.sv
// Shared constants and helpers for the fifo_buf_ctrl FIFO and its storage.
package fifo_buf_pkg;

    localparam int WIDTH_DEF      = 64;
    localparam int DEPTH_LOG2_DEF = 6;
    localparam int N              = 2 ** DEPTH_LOG2_DEF;
    localparam int AF_THRESH_DEF  = N - 4;
    localparam int AE_THRESH_DEF  = 4;

    // Bits needed to hold an occupancy of 0..2**depth_log2 inclusive.
    function automatic int cnt_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/fifo_buf_ctrl_if.sv
// Handshake and status bundle between a FIFO user (master) and fifo_buf_ctrl (slave).
interface fifo_buf_ctrl_if
    import fifo_buf_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
);
    localparam int CW = cnt_width(DEPTH_LOG2);

    logic             flush;
    logic             wr;
    logic [WIDTH-1:0] w_data;
    logic             rd;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic [CW-1:0]    space;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, wr, w_data, rd,
        input  r_data, r_valid, full, empty, almost_full, almost_empty,
               count, space, overflow, underflow
    );

    modport slave (
        input  flush, wr, w_data, rd,
        output r_data, r_valid, full, empty, almost_full, almost_empty,
               count, space, overflow, underflow
    );

endinterface

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port FIFO storage: synchronous write, asynchronous read.
// Build option FIFO_BUF_REG_OUT_EN turns the read port into a registered one
// that loads only when re_i is high and otherwise holds its last word.
module fifo_sdp_ram #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);
    logic [WIDTH-1:0] mem_q [2 ** ADDR_W];

    // Write port.
    // NOTE: storage has no reset; occupancy lives in the controller, so stale words are never observed.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

`ifdef FIFO_BUF_REG_OUT_EN
    logic [WIDTH-1:0] rdata_q;

    // Registered read port: captures the head word on an accepted pop.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
`else
    logic unused_re;

    assign unused_re = re_i;
    assign rdata_o   = mem_q[raddr_i];
`endif

endmodule

// File: rtl/fifo_buf_ctrl.sv
// Synchronous FIFO controller with exact count/space, threshold flags,
// synchronous flush and sticky overflow/underflow.
// Build option FIFO_BUF_REG_OUT_EN: registered read data with a one-cycle
// r_valid pulse per accepted read; otherwise show-ahead read of the head word.
module fifo_buf_ctrl
    import fifo_buf_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int AF_THRESH  = 2 ** DEPTH_LOG2 - 4,
    parameter int AE_THRESH  = AE_THRESH_DEF
) (
    input logic             clk,
    input logic             reset,
    fifo_buf_ctrl_if.slave  bus
);
    localparam int            CW    = cnt_width(DEPTH_LOG2);
    localparam logic [CW-1:0] N_CNT = CW'(2 ** DEPTH_LOG2);

    logic [DEPTH_LOG2-1:0] w_ptr_q, w_ptr_d;
    logic [DEPTH_LOG2-1:0] r_ptr_q, r_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  full, empty;
    logic                  wr_acc, rd_acc;

    // Status is a pure function of the registered count.
    assign full  = (count_q == N_CNT);
    assign empty = (count_q == '0);

    // Request acceptance and next-state for pointers, count and error flags.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves a latch.
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        rd_acc      = 1'b0;
        wr_acc      = 1'b0;

        if (bus.flush) begin
            // Flush drops any same-cycle request and keeps the sticky flags.
            w_ptr_d = '0;
            r_ptr_d = '0;
            count_d = '0;
        end else begin
            rd_acc = bus.rd & ~empty;
            wr_acc = bus.wr & (~full | rd_acc);

            if (wr_acc) w_ptr_d = w_ptr_q + 1'b1;
            if (rd_acc) r_ptr_d = r_ptr_q + 1'b1;

            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase

            if (bus.wr && !wr_acc) overflow_d  = 1'b1;
            if (bus.rd && empty)   underflow_d = 1'b1;
        end
    end

    // Controller state register with synchronous reset.
    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_sdp_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc & ~reset),
        .waddr_i (w_ptr_q),
        .wdata_i (bus.w_data),
        .re_i    (rd_acc & ~reset),
        .raddr_i (r_ptr_q),
        .rdata_o (bus.r_data)
    );

`ifdef FIFO_BUF_REG_OUT_EN
    logic r_valid_q;

    // One-cycle valid pulse following each accepted read.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= rd_acc;
        end
    end

    assign bus.r_valid = r_valid_q;
`else
    assign bus.r_valid = ~empty;
`endif

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
    assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
    assign bus.count        = count_q;
    assign bus.space        = N_CNT - count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_buf_ctrl.sv
// Directed self-checking bench for fifo_buf_ctrl (show-ahead build),
// configured as an 8-entry, 64-bit FIFO with AF=6 and AE=2.
module tb_fifo_buf_ctrl;

    localparam int WIDTH      = 64;
    localparam int DEPTH_LOG2 = 3;
    localparam int NE         = 8;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fifo_buf_ctrl_if #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

    fifo_buf_ctrl #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .AF_THRESH  (6),
        .AE_THRESH  (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush  = 1'b0;
        bus.wr     = 1'b0;
        bus.rd     = 1'b0;
        bus.w_data = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", bus.full); end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        checks++; if (bus.space !== 4'd8) begin errors++; $display("FAIL reset_space got %0d exp 8", bus.space); end
        checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got %0b exp 1", bus.almost_empty); end
        checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %0b exp 0", bus.almost_full); end
        checks++; if (bus.r_valid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %0b exp 0", bus.r_valid); end
        checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin errors++; $display("FAIL reset_errflags got %b exp 00", {bus.overflow, bus.underflow}); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < NE; i++) begin
            bus.wr     = 1'b1;
            bus.w_data = 64'h10 + 64'(i);
            tick();
            checks++; if (int'(bus.count) !== i + 1) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, bus.count, i + 1); end
            checks++; if (bus.almost_full !== (i + 1 >= 6)) begin errors++; $display("FAIL fill_af[%0d] got %0b exp %0b", i, bus.almost_full, (i + 1 >= 6)); end
            checks++; if (bus.almost_empty !== (i + 1 <= 2)) begin errors++; $display("FAIL fill_ae[%0d] got %0b exp %0b", i, bus.almost_empty, (i + 1 <= 2)); end
            checks++; if (bus.full !== (i + 1 == NE)) begin errors++; $display("FAIL fill_full[%0d] got %0b exp %0b", i, bus.full, (i + 1 == NE)); end
        end
        checks++; if (bus.space !== 4'd0) begin errors++; $display("FAIL fill_space got %0d exp 0", bus.space); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fill_no_ovf got %0b exp 0", bus.overflow); end
        bus.w_data = 64'h99;
        tick();
        idle();
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b exp 1", bus.overflow); end
        checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d exp 8", bus.count); end
        checks++; if (bus.r_data !== 64'h10) begin errors++; $display("FAIL ovf_head got %h exp 10", bus.r_data); end
    endtask

    task automatic test_full_rdwr();
        logic [63:0] exp_seq [8];
        exp_seq = '{64'h11, 64'h12, 64'h13, 64'h14, 64'h15, 64'h16, 64'h17, 64'h20};
        bus.wr     = 1'b1;
        bus.rd     = 1'b1;
        bus.w_data = 64'h20;
        tick();
        idle();
        checks++; if (bus.r_data !== 64'h11) begin errors++; $display("FAIL full_rw_head got %h exp 11", bus.r_data); end
        checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL full_rw_count got %0d exp 8", bus.count); end
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL full_rw_full got %0b exp 1", bus.full); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL full_rw_ovf got %0b exp 1", bus.overflow); end
        for (int i = 0; i < NE; i++) begin
            checks++; if (bus.r_data !== exp_seq[i]) begin errors++; $display("FAIL drain[%0d] got %h exp %h", i, bus.r_data, exp_seq[i]); end
            bus.rd = 1'b1;
            tick();
        end
        idle();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %0b exp 1", bus.empty); end
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL drain_unf got %0b exp 0", bus.underflow); end
    endtask

    task automatic test_empty_rdwr();
        bus.wr     = 1'b1;
        bus.rd     = 1'b1;
        bus.w_data = 64'hAA;
        tick();
        idle();
        checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL empty_rw_count got %0d exp 1", bus.count); end
        checks++; if (bus.r_data !== 64'hAA) begin errors++; $display("FAIL empty_rw_head got %h exp aa", bus.r_data); end
        checks++; if (bus.r_valid !== 1'b1) begin errors++; $display("FAIL empty_rw_rvalid got %0b exp 1", bus.r_valid); end
        checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL empty_rw_unf got %0b exp 1", bus.underflow); end
        bus.rd = 1'b1;
        tick();
        idle();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL empty_rw_pop got %0b exp 1", bus.empty); end
    endtask

    task automatic test_wrap();
        logic [63:0] model_q[$];
        int pushed = 0;
        int popped = 0;
        int mcnt   = 0;
        bit rd_a, wr_a;
        for (int c = 0; c < 80 && popped < 12; c++) begin
            bus.wr     = (pushed < 12);
            bus.rd     = (pushed >= 12) || (c % 3 == 2);
            bus.w_data = 64'h100 + 64'(pushed);
            rd_a = bus.rd && (mcnt > 0);
            wr_a = bus.wr && ((mcnt < NE) || rd_a);
            tick();
            if (rd_a) begin void'(model_q.pop_front()); popped++; mcnt--; end
            if (wr_a) begin model_q.push_back(64'h100 + 64'(pushed)); pushed++; mcnt++; end
            checks++; if (int'(bus.count) !== mcnt) begin errors++; $display("FAIL wrap_count[%0d] got %0d exp %0d", c, bus.count, mcnt); end
            checks++; if (int'(bus.count) + int'(bus.space) !== NE) begin errors++; $display("FAIL wrap_sum[%0d] got %0d exp 8", c, int'(bus.count) + int'(bus.space)); end
            if (mcnt > 0) begin
                checks++; if (bus.r_data !== model_q[0]) begin errors++; $display("FAIL wrap_head[%0d] got %h exp %h", c, bus.r_data, model_q[0]); end
            end
        end
        idle();
        checks++; if (popped !== 12) begin errors++; $display("FAIL wrap_timeout got %0d pops exp 12", popped); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %0b exp 1", bus.empty); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            bus.wr     = 1'b1;
            bus.w_data = 64'h30 + 64'(i);
            tick();
        end
        checks++; if (bus.count !== 4'd5) begin errors++; $display("FAIL pre_flush_count got %0d exp 5", bus.count); end
        bus.flush  = 1'b1;
        bus.wr     = 1'b1;
        bus.w_data = 64'h55;
        tick();
        idle();
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %0b exp 1", bus.empty); end
        checks++; if ({bus.overflow, bus.underflow} !== 2'b11) begin errors++; $display("FAIL flush_sticky got %b exp 11", {bus.overflow, bus.underflow}); end
        tick();
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL flush_wr_dropped got %0d exp 0", bus.count); end
        bus.wr     = 1'b1;
        bus.w_data = 64'h66;
        tick();
        idle();
        checks++; if (bus.r_data !== 64'h66) begin errors++; $display("FAIL post_flush_head got %h exp 66", bus.r_data); end
    endtask

    task automatic test_reset_mid();
        bus.wr     = 1'b1;
        bus.w_data = 64'h70;
        tick();
        bus.w_data = 64'h71;
        tick();
        reset      = 1'b1;
        bus.w_data = 64'h72;
        tick();
        reset = 1'b0;
        idle();
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL rst_mid_count got %0d exp 0", bus.count); end
        checks++; if (bus.space !== 4'd8) begin errors++; $display("FAIL rst_mid_space got %0d exp 8", bus.space); end
        checks++; if ({bus.empty, bus.almost_empty, bus.full, bus.almost_full} !== 4'b1100) begin errors++; $display("FAIL rst_mid_flags got %b exp 1100", {bus.empty, bus.almost_empty, bus.full, bus.almost_full}); end
        checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin errors++; $display("FAIL rst_mid_errflags got %b exp 00", {bus.overflow, bus.underflow}); end
        checks++; if (bus.r_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_rvalid got %0b exp 0", bus.r_valid); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_rdwr();
        test_empty_rdwr();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_buf_ctrl.md
Name: fifo_buf_ctrl

Overview:
- Parametrised synchronous FIFO; next generation of the team's 64-bit memory FIFO buffer.
- Adds exact occupancy and space counts, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow flags.
- Sits between the PHY receive/transmit datapaths and downstream consumers; single clock domain.

Parameters:
- WIDTH, 64, data word width in bits.
- DEPTH_LOG2, 6, log2 of entry count; N = 2**DEPTH_LOG2 entries.
- AF_THRESH, 2**DEPTH_LOG2-4, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of FIFO contents.
- wr  in  1  write request.
- w_data  in  WIDTH  write data.
- rd  in  1  read request; pops the head word.
- r_data  out  WIDTH  head word (see Behaviour / Optional Feature).
- r_valid  out  1  r_data is valid.
- full, empty  out  1 each  status flags.
- almost_full, almost_empty  out  1 each  threshold flags.
- count  out  DEPTH_LOG2+1  entries held, 0..N.
- space  out  DEPTH_LOG2+1  free entries, always N - count.
- overflow, underflow  out  1 each  sticky error flags.

Behaviour:
- Reset values (on reset=1 at a clk edge):
  - w_ptr = r_ptr = 0; count = 0; space = N.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = underflow = 0; r_valid = 0.
  - Memory contents are not cleared.
- Priority per cycle: reset > flush > rd/wr.
  - flush: clears pointers and count as reset does; overflow/underflow are retained.
  - A wr or rd in the same cycle as flush is discarded.
- Request acceptance:
  - Write accepted: wr_acc = wr & (~full | rd_acc).
  - Read accepted: rd_acc = rd & ~empty.
- count update, registered:
  - +1 on write only; -1 on read only; unchanged on both or neither.
  - All flags and space are derived from the registered count, so they are valid in the same cycle as count.
- Pointers are DEPTH_LOG2 bits and wrap naturally from N-1 to 0. No pointer-difference arithmetic; count is the sole source of occupancy.
- Empty FIFO with rd=1, wr=1: write is accepted, read is ignored, underflow is set.
- Full FIFO with rd=1, wr=1: both are accepted; full stays 1; no overflow.
- Error flags:
  - overflow is set when wr=1 and the write is not accepted.
  - underflow is set when rd=1 and empty=1.
  - Both are sticky until reset.
- Default read path (show-ahead):
  - r_data = mem[r_ptr] combinationally.
  - r_valid = ~empty.
  - Latency from write to visibility is 1 cycle; a word written at edge k is visible after edge k.

Optional Feature:
- Macro: FIFO_BUF_REG_OUT_EN.
- Defined:
  - r_data is registered: loaded with mem[r_ptr] on the edge where rd_acc=1.
  - r_valid pulses high for exactly the cycle after each accepted read; otherwise 0.
  - Read latency is 1 cycle.
  - Reset or flush clears r_valid; r_data holds its value.
- Undefined: default show-ahead path as above.

Decomposition:
- Shared package fifo_buf_pkg:
  - Localparam for N.
  - Count-width function clog2-style.
  - Default threshold constants.
- One sub-module: fifo_sdp_ram.
  - Simple dual-port storage: synchronous write, asynchronous read.
  - With FIFO_BUF_REG_OUT_EN it uses a registered read port.
  - Controller logic stays in fifo_buf_ctrl.

Test Plan (DEPTH_LOG2=3, N=8, AF_THRESH=6, AE_THRESH=2, WIDTH=64):
- Reset then idle -> empty=1, count=0, space=8, almost_empty=1, r_valid=0, overflow=underflow=0.
- Write 8 words 0x10..0x17 -> full=1 after 8th edge, count=8, space=0; almost_full first high at count=6. A 9th write is dropped, overflow=1, and the head is still 0x10.
- Full FIFO, rd=wr=1 with 0x20 -> r_data steps 0x10→0x11, count stays 8, full stays 1, overflow unchanged. Drain 8 reads -> sequence 0x11..0x17,0x20, empty=1.
- Empty FIFO, rd=wr=1 with 0xAA -> count=1, r_data=0xAA, underflow=1. A following rd-only pop -> empty=1.
- Push 12, pop 12 interleaved to force pointer wrap -> data order preserved; count never exceeds 8; space+count=8 every cycle.
- Fill 5 entries, assert flush with wr=1 -> next cycle count=0, empty=1, the written word is discarded, and sticky flags are retained. Reset mid-burst -> all reset values on the next cycle.
